// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller:
// CSR addresses, CSR op encodings, FSM states, mstatus bit positions.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HANDLE = 2'd1,
        ST_RETURN = 2'd2
    } state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Core-side bundle of the trap controller: exceptions, mret, irq lines,
// CSR requests, and fetch redirects. Core is master, trap_ctrl is slave.
interface trap_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 8
);
    logic               exc_valid;
    logic [XLEN-1:0]    exc_cause;
    logic [XLEN-1:0]    pc_actual;
    logic               mret;
    logic [NUM_IRQ-1:0] irq;
    logic               csr_op_valid;
    logic [1:0]         csr_op_type;
    logic [11:0]        csr_op_addr;
    logic [XLEN-1:0]    csr_op_wdata;
    logic [XLEN-1:0]    csr_op_rdata;
    logic               csr_op_done;
    logic               csr_op_illegal;
    logic               trap_take;
    logic [XLEN-1:0]    trap_vector;
    logic               ret_take;
    logic [XLEN-1:0]    mepc_out;
    logic               exception_handling_flag;

    modport master (
        output exc_valid, exc_cause, pc_actual, mret, irq,
        output csr_op_valid, csr_op_type, csr_op_addr, csr_op_wdata,
        input  csr_op_rdata, csr_op_done, csr_op_illegal,
        input  trap_take, trap_vector, ret_take, mepc_out,
        input  exception_handling_flag
    );

    modport slave (
        input  exc_valid, exc_cause, pc_actual, mret, irq,
        input  csr_op_valid, csr_op_type, csr_op_addr, csr_op_wdata,
        output csr_op_rdata, csr_op_done, csr_op_illegal,
        output trap_take, trap_vector, ret_take, mepc_out,
        output exception_handling_flag
    );
endinterface

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   idx
);
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end
endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller with NUM_IRQ prioritised interrupts.
// Optional mscratch CSR enabled by defining TRAP_MSCRATCH_EN.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 8,
    parameter int              IRQ_BASE    = 16,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input logic        clk,
    input logic        rst,
    trap_ctrl_if.slave bus
);
    logic [XLEN-1:0]    mstatus, mie, mtvec, mepc, mcause, mip;
`ifdef TRAP_MSCRATCH_EN
    logic [XLEN-1:0]    mscratch;
`endif
    state_e             state;
    logic [XLEN-1:0]    irq_vec, base, old, nv;
    logic [XLEN-1:0]    int_cause, int_vec;
    logic [NUM_IRQ-1:0] pend;
    logic               pend_valid;
    logic [3:0]         pend_idx;
    logic               known, we, int_req, active;
    logic               take_exc, take_int, do_ret, csr_acc;
    csr_op_e            op;

    irq_prio_enc #(.N(NUM_IRQ)) u_enc (
        .req   (pend),
        .valid (pend_valid),
        .idx   (pend_idx)
    );

    always_comb begin
        irq_vec = '0;
        irq_vec[IRQ_BASE +: NUM_IRQ] = bus.irq;
    end

    assign pend      = mip[IRQ_BASE +: NUM_IRQ] & mie[IRQ_BASE +: NUM_IRQ];
    assign int_req   = mstatus[MSTATUS_MIE] & pend_valid;
    assign int_cause = XLEN'(IRQ_BASE) + XLEN'(pend_idx);
    assign base      = {mtvec[XLEN-1:2], 2'b00};
    assign int_vec   = mtvec[0] ? base + (int_cause << 2) : base;

    assign active   = (state == ST_IDLE) | (state == ST_HANDLE);
    assign take_exc = active & bus.exc_valid;
    assign take_int = (state == ST_IDLE) & ~bus.exc_valid & int_req;
    assign do_ret   = (state == ST_HANDLE) & bus.mret & ~bus.exc_valid;
    assign csr_acc  = active & bus.csr_op_valid
                    & ~take_exc & ~take_int & ~do_ret;
    assign op       = csr_op_e'(bus.csr_op_type);

    always_comb begin
        old   = '0;
        known = 1'b1;
        unique case (1'b1)
            (bus.csr_op_addr == CSR_MSTATUS): old = mstatus;
            (bus.csr_op_addr == CSR_MIE):     old = mie;
            (bus.csr_op_addr == CSR_MTVEC):   old = mtvec;
            (bus.csr_op_addr == CSR_MEPC):    old = mepc;
            (bus.csr_op_addr == CSR_MCAUSE):  old = mcause;
            (bus.csr_op_addr == CSR_MIP):     old = mip;
`ifdef TRAP_MSCRATCH_EN
            (bus.csr_op_addr == CSR_MSCRATCH): old = mscratch;
`endif
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        nv = old;
        unique case (op)
            OP_READ:  nv = old;
            OP_WRITE: nv = bus.csr_op_wdata;
            OP_SET:   nv = old | bus.csr_op_wdata;
            OP_CLEAR: nv = old & ~bus.csr_op_wdata;
        endcase
    end

    // set/clear with a zero mask is a pure read
    assign we = known & ((op == OP_WRITE)
              | (((op == OP_SET) | (op == OP_CLEAR)) & (|bus.csr_op_wdata)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mstatus    <= '0;
            mie        <= '0;
            mtvec      <= RESET_MTVEC;
            mepc       <= '0;
            mcause     <= '0;
            mip        <= '0;
`ifdef TRAP_MSCRATCH_EN
            mscratch   <= '0;
`endif
            bus.trap_take      <= 1'b0;
            bus.trap_vector    <= '0;
            bus.ret_take       <= 1'b0;
            bus.mepc_out       <= '0;
            bus.csr_op_done    <= 1'b0;
            bus.csr_op_illegal <= 1'b0;
            bus.csr_op_rdata   <= '0;
            bus.exception_handling_flag <= 1'b0;
        end else begin
            mip                <= irq_vec;
            bus.trap_take      <= 1'b0;
            bus.trap_vector    <= '0;
            bus.ret_take       <= 1'b0;
            bus.mepc_out       <= '0;
            bus.csr_op_done    <= 1'b0;
            bus.csr_op_illegal <= 1'b0;
            bus.csr_op_rdata   <= '0;
            if (take_exc | take_int) begin
                mcause <= take_exc ? bus.exc_cause
                                   : {1'b1, int_cause[XLEN-2:0]};
                mepc   <= {bus.pc_actual[XLEN-1:2], 2'b00};
                mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
                mstatus[MSTATUS_MIE]  <= 1'b0;
                bus.trap_take   <= 1'b1;
                bus.trap_vector <= take_exc ? base : int_vec;
                bus.exception_handling_flag <= 1'b1;
                state <= ST_HANDLE;
            end else if (do_ret) begin
                bus.ret_take <= 1'b1;
                bus.mepc_out <= mepc;
                bus.exception_handling_flag <= 1'b0;
                state <= ST_RETURN;
            end else begin
                if (state == ST_RETURN) begin
                    mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
                    mstatus[MSTATUS_MPIE] <= 1'b1;
                    state <= ST_IDLE;
                end
                if (csr_acc) begin
                    bus.csr_op_done    <= 1'b1;
                    bus.csr_op_illegal <= ~known;
                    bus.csr_op_rdata   <= old;
                    if (we) begin
                        unique case (1'b1)
                            (bus.csr_op_addr == CSR_MSTATUS): mstatus <= nv;
                            (bus.csr_op_addr == CSR_MIE):     mie     <= nv;
                            (bus.csr_op_addr == CSR_MTVEC):
                                mtvec <= {nv[XLEN-1:2], 1'b0, nv[0]};
                            (bus.csr_op_addr == CSR_MEPC):
                                mepc <= {nv[XLEN-1:2], 2'b00};
                            (bus.csr_op_addr == CSR_MCAUSE):  mcause  <= nv;
`ifdef TRAP_MSCRATCH_EN
                            (bus.csr_op_addr == CSR_MSCRATCH): mscratch <= nv;
`endif
                            default: ;
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios then random traffic
// against a cycle-level behavioural model of the CSR/trap rules.
module tb_trap_ctrl;
    localparam int XLEN     = 32;
    localparam int NUM_IRQ  = 8;
    localparam int IRQ_BASE = 16;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    trap_ctrl_if #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) bus ();

    trap_ctrl #(
        .XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .IRQ_BASE(IRQ_BASE),
        .RESET_MTVEC('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state: 0 = idle, 1 = handling, 2 = returning
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip, m_scratch;
    int          m_mode;
    logic        e_take, e_ret, e_done, e_ill, e_flag;
    logic [31:0] e_vec, e_mepc_out, e_rdata;

    function automatic logic [31:0] csr_rd(input logic [11:0] a, output bit known);
        known = 1'b1;
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
`ifdef TRAP_MSCRATCH_EN
            12'h340: return m_scratch;
`endif
            default: begin known = 1'b0; return 32'h0; end
        endcase
    endfunction

    function automatic void csr_wr(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: m_mstatus = v;
            12'h304: m_mie     = v;
            12'h305: m_mtvec   = v & ~32'h2;
            12'h341: m_mepc    = v & ~32'h3;
            12'h342: m_mcause  = v;
`ifdef TRAP_MSCRATCH_EN
            12'h340: m_scratch = v;
`endif
            default: ;
        endcase
    endfunction

    function automatic void enter_trap(input logic [31:0] c, input logic [31:0] v);
        m_mcause     = c;
        m_mepc       = bus.pc_actual & ~32'h3;
        m_mstatus[7] = m_mstatus[3];
        m_mstatus[3] = 1'b0;
        e_take       = 1'b1;
        e_vec        = v;
        m_mode       = 1;
    endfunction

    function automatic void model_eval();
        int          k;
        int          cause;
        bit          known;
        logic [31:0] base, old, nv;
        e_take = 0; e_ret = 0; e_done = 0; e_ill = 0;
        e_vec = 0; e_mepc_out = 0; e_rdata = 0;
        if (rst) begin
            m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0;
            m_mcause = 0; m_mip = 0; m_scratch = 0; m_mode = 0;
            e_flag = 0;
            return;
        end
        k = -1;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (m_mip[IRQ_BASE+i] && m_mie[IRQ_BASE+i]) k = i;
        base = m_mtvec & ~32'h3;
        if (m_mode != 2 && bus.exc_valid) begin
            enter_trap(bus.exc_cause, base);
        end else if (m_mode == 0 && m_mstatus[3] && k >= 0) begin
            cause = IRQ_BASE + k;
            enter_trap(32'h8000_0000 | cause,
                       m_mtvec[0] ? base + 4 * cause : base);
        end else if (m_mode == 1 && bus.mret) begin
            e_ret      = 1;
            e_mepc_out = m_mepc;
            m_mode     = 2;
        end else if (m_mode == 2) begin
            m_mstatus[3] = m_mstatus[7];
            m_mstatus[7] = 1'b1;
            m_mode       = 0;
        end else if (bus.csr_op_valid) begin
            old     = csr_rd(bus.csr_op_addr, known);
            e_done  = 1;
            e_ill   = !known;
            e_rdata = known ? old : 32'h0;
            nv = old;
            case (bus.csr_op_type)
                2'd1: nv = bus.csr_op_wdata;
                2'd2: nv = old | bus.csr_op_wdata;
                2'd3: nv = old & ~bus.csr_op_wdata;
                default: ;
            endcase
            if (known && bus.csr_op_type != 2'd0) csr_wr(bus.csr_op_addr, nv);
        end
        m_mip = 32'(bus.irq) << IRQ_BASE;
        e_flag = (m_mode == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        chk("trap_take", 32'(bus.trap_take), 32'(e_take));
        chk("ret_take", 32'(bus.ret_take), 32'(e_ret));
        chk("csr_done", 32'(bus.csr_op_done), 32'(e_done));
        chk("flag", 32'(bus.exception_handling_flag), 32'(e_flag));
        if (e_take) chk("trap_vector", bus.trap_vector, e_vec);
        if (e_ret) chk("mepc_out", bus.mepc_out, e_mepc_out);
        if (e_done) begin
            chk("csr_rdata", bus.csr_op_rdata, e_rdata);
            chk("csr_illegal", 32'(bus.csr_op_illegal), 32'(e_ill));
        end
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.csr_op_valid = 1'b1;
        bus.csr_op_type  = op;
        bus.csr_op_addr  = a;
        bus.csr_op_wdata = d;
        step();
        bus.csr_op_valid = 1'b0;
    endtask

    logic [11:0] addrs [9];

    initial begin
        vectors = 0;
        miscompares = 0;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h344, 12'h7FF, 12'h301};
        rst = 1'b1;
        bus.exc_valid = 0; bus.exc_cause = 0; bus.pc_actual = 0;
        bus.mret = 0; bus.irq = 0; bus.csr_op_valid = 0;
        bus.csr_op_type = 0; bus.csr_op_addr = 0; bus.csr_op_wdata = 0;
        step();
        step();
        chk("rst_rdata", bus.csr_op_rdata, 32'h0);
        chk("rst_vector", bus.trap_vector, 32'h0);
        rst = 1'b0;

        // synchronous exception, direct mode
        csr(2'd1, 12'h305, 32'h1000);
        csr(2'd1, 12'h300, 32'h8);
        bus.exc_valid = 1; bus.exc_cause = 2; bus.pc_actual = 32'h200;
        step();
        bus.exc_valid = 0;
        chk("exc_take", 32'(bus.trap_take), 32'h1);
        chk("exc_vec", bus.trap_vector, 32'h1000);
        chk("exc_flag", 32'(bus.exception_handling_flag), 32'h1);
        csr(2'd0, 12'h341, 0);
        chk("exc_mepc", bus.csr_op_rdata, 32'h200);
        csr(2'd0, 12'h342, 0);
        chk("exc_mcause", bus.csr_op_rdata, 32'h2);
        csr(2'd0, 12'h300, 0);
        chk("exc_mstatus", bus.csr_op_rdata, 32'h80);

        bus.mret = 1;
        step();
        bus.mret = 0;
        chk("ret_take", 32'(bus.ret_take), 32'h1);
        chk("ret_mepc", bus.mepc_out, 32'h200);
        step();
        csr(2'd0, 12'h300, 0);
        chk("ret_mstatus", bus.csr_op_rdata, 32'h88);

        // vectored interrupt, irq[3] beats irq[5]
        csr(2'd1, 12'h305, 32'h1001);
        csr(2'd1, 12'h304, (32'h1 << 19) | (32'h1 << 21));
        bus.irq = 8'h28;
        step();
        step();
        chk("irq_take", 32'(bus.trap_take), 32'h1);
        chk("irq_vec", bus.trap_vector, 32'h104C);
        bus.irq = 0;
        csr(2'd0, 12'h342, 0);
        chk("irq_mcause", bus.csr_op_rdata, 32'h8000_0013);
        bus.mret = 1;
        step();
        bus.mret = 0;
        step();

        // set/clear semantics and unknown address
        csr(2'd1, 12'h304, 32'h5);
        csr(2'd2, 12'h304, 32'h2);
        chk("set_old", bus.csr_op_rdata, 32'h5);
        csr(2'd3, 12'h304, 32'h0);
        chk("clr0_old", bus.csr_op_rdata, 32'h7);
        csr(2'd0, 12'h304, 0);
        chk("clr0_keep", bus.csr_op_rdata, 32'h7);
        csr(2'd0, 12'h7FF, 0);
        chk("unk_ill", 32'(bus.csr_op_illegal), 32'h1);
        chk("unk_rdata", bus.csr_op_rdata, 32'h0);

        // exception beats a CSR request; request completes next cycle
        bus.exc_valid = 1; bus.exc_cause = 5; bus.pc_actual = 32'h344;
        bus.csr_op_valid = 1; bus.csr_op_type = 0; bus.csr_op_addr = 12'h304;
        step();
        bus.exc_valid = 0;
        chk("race_nodone", 32'(bus.csr_op_done), 32'h0);
        chk("race_take", 32'(bus.trap_take), 32'h1);
        step();
        bus.csr_op_valid = 0;
        chk("race_done", 32'(bus.csr_op_done), 32'h1);
        chk("race_rdata", bus.csr_op_rdata, 32'h7);

        // reset while handling
        rst = 1;
        step();
        rst = 0;
        chk("rst_mid_flag", 32'(bus.exception_handling_flag), 32'h0);
        csr(2'd0, 12'h305, 0);
        chk("rst_mtvec", bus.csr_op_rdata, 32'h0);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.exc_valid = ($urandom_range(0, 11) == 0);
            bus.exc_cause = 32'($urandom_range(0, 15));
            bus.pc_actual = $urandom;
            bus.mret = ($urandom_range(0, 3) == 0);
            bus.irq = 8'($urandom & $urandom);
            bus.csr_op_valid = $urandom_range(0, 1);
            bus.csr_op_type = 2'($urandom_range(0, 3));
            bus.csr_op_addr = addrs[$urandom_range(0, 8)];
            bus.csr_op_wdata = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            step();
        end
        rst = 0;
        bus.exc_valid = 0; bus.mret = 0; bus.csr_op_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised machine-mode trap controller; next generation of the single-exception handler.
- Adds NUM_IRQ external interrupt lines with mie/mip masking and fixed-priority arbitration.
- Single-cycle trap entry and return; CSR accesses also served while a trap is being handled; all CSR ops return the old value.
- Sits between the core's decode/commit stage (exceptions, mret, CSR instructions) and fetch (trap_vector, mepc_out).

Parameters:
XLEN, 32, data/CSR width
NUM_IRQ, 8, external interrupt lines (1..16)
IRQ_BASE, 16, mip/mie bit and cause code of irq[0]; IRQ_BASE+NUM_IRQ <= XLEN
RESET_MTVEC, 0, mtvec reset value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
exc_valid  in  1  synchronous exception this cycle
exc_cause  in  XLEN  exception code (bit XLEN-1 must be 0)
pc_actual  in  XLEN  PC of faulting or interrupted instruction
mret  in  1  return from trap
irq  in  NUM_IRQ  level-sensitive interrupt lines
csr_op_valid  in  1  CSR instruction request
csr_op_type  in  2  0=read 1=write 2=set 3=clear
csr_op_addr  in  12  CSR address
csr_op_wdata  in  XLEN  rs1/zimm
csr_op_rdata  out  XLEN  old CSR value
csr_op_done  out  1  one-cycle completion pulse
csr_op_illegal  out  1  with done: unknown address
trap_take  out  1  one-cycle pulse: redirect fetch to trap_vector
trap_vector  out  XLEN  handler address, valid with trap_take
ret_take  out  1  one-cycle pulse: redirect fetch to mepc_out
mepc_out  out  XLEN  mepc, valid with ret_take
exception_handling_flag  out  XLEN?no: 1  high while in HANDLE

Behaviour:
- Reset: all outputs 0; mstatus/mie/mepc/mcause/mip = 0; mtvec = RESET_MTVEC; state IDLE.
- CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344. mip is read-only, registered copy of irq placed at bits IRQ_BASE+k. Writes to mip are ignored without flagging illegal. mtvec bit1 forced 0 on write. mepc bits[1:0] forced 0.
- Interrupt pending: int_req = mstatus.MIE(bit3) & |(mip & mie). Cause = IRQ_BASE + lowest k pending and enabled; mcause bit XLEN-1 = 1.
- FSM states: IDLE, HANDLE, RETURN.
- IDLE priority: exc_valid > int_req > csr_op_valid.
  - Trap (exception or interrupt), at the sampling edge:
    - mcause <= cause
    - mepc <= pc_actual
    - MPIE(bit7) <= MIE; MIE <= 0
    - trap_take=1 the next cycle; state -> HANDLE
  - trap_vector: base = {mtvec[XLEN-1:2],2'b00}. If mtvec[0]=1 and the trap is an interrupt: base + 4*cause code. Otherwise (exceptions, or direct mode): base.
- HANDLE: exception_handling_flag=1; interrupts are masked because MIE=0.
  - mret -> RETURN.
  - exc_valid in HANDLE re-enters the trap (mcause/mepc overwritten, trap_take pulses, stays HANDLE).
  - exc_valid together with mret: the exception wins.
- RETURN (1 cycle):
  - MIE <= MPIE; MPIE <= 1
  - ret_take=1 and mepc_out=mepc in the same cycle
  - flag cleared; state -> IDLE
- CSR op, accepted in IDLE or HANDLE when no trap/mret wins that cycle:
  - csr_op_rdata = old value; done pulses the next cycle; update at the same edge.
  - Write: new = wdata. Set: old|wdata. Clear: old&~wdata. Set/clear with wdata=0 performs no write.
  - A request that loses to a trap or mret is not done; the requester holds valid.
  - Unknown address: rdata 0, illegal=1, no state change.
- Reset mid-trap: returns to IDLE, and any pending pulse is dropped.

Optional Feature:
- TRAP_MSCRATCH_EN
  - Defined: adds mscratch (0x340), reset 0, full read/write/set/clear.
  - Undefined: 0x340 is an unknown address (illegal).

Decomposition:
- Shared package trap_pkg:
  - CSR address constants
  - csr op type encodings
  - FSM state encodings
  - mstatus bit positions MIE=3, MPIE=7
- Sub-module irq_prio_enc: NUM_IRQ-wide lowest-index priority encoder (valid + index).

Test Plan:
- mtvec=0x1000, mstatus=0x8, exc_valid cause=2, pc=0x200 -> next cycle: trap_take=1, trap_vector=0x1000, mepc=0x200, mcause=2, mstatus=0x80, flag=1.
- mtvec=0x1001, mie bit19 set, irq[3]=1 -> mcause=0x80000013, trap_vector=0x104C; irq[3] and irq[5] enabled -> cause 19 chosen.
- mret in HANDLE -> ret_take=1, mepc_out=0x200, mstatus=0x88, then IDLE.
- mie=0x5, set op wdata=0x2 -> rdata=0x5, mie=0x7; clear op wdata=0 -> rdata=0x7, no change; read 0x7FF -> illegal=1, rdata=0.
- exc_valid and csr_op_valid in the same IDLE cycle -> trap taken, no done; done follows the next accepted cycle.
- rst asserted in HANDLE -> IDLE, all outputs 0, mtvec=RESET_MTVEC.
